// File: rtl/chan_responder_pkg.sv
// Shared message codes, bus widths and FSM encodings for the CPU channel responder.
package chan_responder_pkg;

    localparam int unsigned CPU_MSG_SIZE = 4;
    localparam int unsigned ADDR_SIZE    = 16;
    localparam int unsigned DATA_SIZE    = 32;

    // Inter-CPU message codes; 0 is reserved as "no message".
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_SET        = 4'h1;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_GET        = 4'h2;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_THREAD_ADDRESS  = 4'h3;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_NO_RESULTS = 4'h4;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_RES_RD     = 4'h5;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_RES_WR     = 4'h6;

    typedef enum logic [1:0] {
        CHR_IDLE   = 2'd0,
        CHR_TADDR  = 2'd1,
        CHR_LOOKUP = 2'd2,
        CHR_REPLY  = 2'd3
    } chr_state_e;

endpackage

// File: rtl/chan_responder_if.sv
// Inter-CPU message bus as seen between a channel initiator (master) and the responder (slave).
interface chan_responder_if;
    import chan_responder_pkg::*;

    logic                    chan_msg_strb;
    logic [CPU_MSG_SIZE-1:0] cpu_msg_in;
    logic [ADDR_SIZE-1:0]    addr_in;
    logic [DATA_SIZE-1:0]    data_in;
    logic [CPU_MSG_SIZE-1:0] cpu_msg_out;
    logic [ADDR_SIZE-1:0]    addr_out;
    logic [DATA_SIZE-1:0]    data_out;
    logic                    cpu_msg_pulse;
    logic                    busy;

    modport master (
        output chan_msg_strb, cpu_msg_in, addr_in, data_in,
        input  cpu_msg_out, addr_out, data_out, cpu_msg_pulse, busy
    );

    modport slave (
        input  chan_msg_strb, cpu_msg_in, addr_in, data_in,
        output cpu_msg_out, addr_out, data_out, cpu_msg_pulse, busy
    );

endinterface

// File: rtl/chan_tag_table.sv
// Associative table of one-word channel mailboxes: parallel tag match, first-free search,
// one write port (allocate or fill) and one clear-full port (drain).
module chan_tag_table
    import chan_responder_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned IW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] i_tag,
    output logic                 o_hit,
    output logic [IW-1:0]        o_hit_idx,
    output logic                 o_hit_full,
    output logic [DATA_SIZE-1:0] o_hit_data,
    output logic                 o_free_avail,
    output logic [IW-1:0]        o_free_idx,
    input  logic                 i_wr_en,
    input  logic [IW-1:0]        i_wr_idx,
    input  logic [ADDR_SIZE-1:0] i_wr_tag,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic                 i_clr_en,
    input  logic [IW-1:0]        i_clr_idx
);

    logic                 r_valid [NCH];
    logic                 r_full  [NCH];
    logic [ADDR_SIZE-1:0] r_tag   [NCH];
    logic [DATA_SIZE-1:0] r_data  [NCH];

    // Parallel tag compare; at most one entry can match since allocation only happens on a miss.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        o_hit_full = 1'b0;
        o_hit_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_valid[i] && (r_tag[i] == i_tag)) begin
                o_hit      = 1'b1;
                o_hit_idx  = IW'(i);
                o_hit_full = r_full[i];
                o_hit_data = r_data[i];
            end
        end
    end

    // Lowest-index invalid entry; scanning downwards lets the lowest index win.
    always_comb begin
        o_free_avail = 1'b0;
        o_free_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                o_free_avail = 1'b1;
                o_free_idx   = IW'(i);
            end
        end
    end

    // Entry storage; entries are only ever freed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_valid[i] <= 1'b0;
                r_full[i]  <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
                r_full[i_wr_idx]  <= 1'b1;
                r_tag[i_wr_idx]   <= i_wr_tag;
                r_data[i_wr_idx]  <= i_wr_data;
            end
            if (i_clr_en) begin
                r_full[i_clr_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/chan_responder.sv
// Dispatcher-side CPU channel responder: request FSM plus registered single-pulse reply.
module chan_responder
    import chan_responder_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clk_oe,
    chan_responder_if.slave  bus
);

    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned TW = $clog2(TMO + 1);

    chr_state_e              r_state, w_state_d;
    logic                    r_op_set, w_op_set_d;
    logic [ADDR_SIZE-1:0]    r_chan, w_chan_d;
    logic [DATA_SIZE-1:0]    r_wdata, w_wdata_d;
    logic [ADDR_SIZE-1:0]    r_tid, w_tid_d;
    logic [TW-1:0]           r_tmo, w_tmo_d;
    logic                    r_pulse, w_pulse_d;
    logic [CPU_MSG_SIZE-1:0] r_msg_out, w_msg_out_d;
    logic [ADDR_SIZE-1:0]    r_addr_out, w_addr_out_d;
    logic [DATA_SIZE-1:0]    r_data_out, w_data_out_d;

    logic                 w_hit, w_hit_full, w_free_avail, w_wr_en, w_clr_en;
    logic [IW-1:0]        w_hit_idx, w_free_idx, w_wr_idx;
    logic [DATA_SIZE-1:0] w_hit_data;

    chan_tag_table #(
        .NCH (NCH)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .i_tag        (r_chan),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .o_hit_full   (w_hit_full),
        .o_hit_data   (w_hit_data),
        .o_free_avail (w_free_avail),
        .o_free_idx   (w_free_idx),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_wr_idx),
        .i_wr_tag     (r_chan),
        .i_wr_data    (r_wdata),
        .i_clr_en     (w_clr_en),
        .i_clr_idx    (w_hit_idx)
    );

    // Next-state, request latching, table update strobes and reply generation.
    always_comb begin
        w_state_d    = r_state;
        w_op_set_d   = r_op_set;
        w_chan_d     = r_chan;
        w_wdata_d    = r_wdata;
        w_tid_d      = r_tid;
        w_tmo_d      = r_tmo;
        w_pulse_d    = r_pulse;
        w_msg_out_d  = r_msg_out;
        w_addr_out_d = r_addr_out;
        w_data_out_d = r_data_out;
        w_wr_en      = 1'b0;
        w_clr_en     = 1'b0;
        w_wr_idx     = w_hit ? w_hit_idx : w_free_idx;
        unique case (r_state)
            CHR_IDLE: begin
                if (bus.chan_msg_strb && ((bus.cpu_msg_in == CPU_R_CHAN_SET) ||
                                          (bus.cpu_msg_in == CPU_R_CHAN_GET))) begin
                    w_op_set_d = (bus.cpu_msg_in == CPU_R_CHAN_SET);
                    w_chan_d   = bus.addr_in;
                    w_wdata_d  = bus.data_in;
                    w_tmo_d    = '0;
                    w_state_d  = CHR_TADDR;
                end
            end
            CHR_TADDR: begin
                // Only the thread address is echoed back, so the thread data address is not kept.
                if (bus.cpu_msg_in == CPU_R_THREAD_ADDRESS) begin
                    w_tid_d   = bus.addr_in;
                    w_tmo_d   = '0;
                    w_state_d = CHR_LOOKUP;
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_tmo_d   = '0;
                    w_state_d = CHR_IDLE;
                end else begin
                    w_tmo_d = r_tmo + TW'(1);
                end
            end
            CHR_LOOKUP: begin
                w_state_d    = CHR_REPLY;
                w_pulse_d    = 1'b1;
                w_addr_out_d = r_tid;
                w_data_out_d = '0;
                w_msg_out_d  = CPU_R_CHAN_NO_RESULTS;
                if (r_op_set) begin
                    if ((w_hit && !w_hit_full) || (!w_hit && w_free_avail)) begin
                        w_wr_en     = i_clk_oe;
                        w_msg_out_d = CPU_R_CHAN_RES_WR;
                    end
                end else if (w_hit && w_hit_full) begin
                    w_clr_en     = i_clk_oe;
                    w_data_out_d = w_hit_data;
                    w_msg_out_d  = CPU_R_CHAN_RES_RD;
                end
            end
            CHR_REPLY: begin
                w_state_d    = CHR_IDLE;
                w_pulse_d    = 1'b0;
                w_msg_out_d  = '0;
                w_addr_out_d = '0;
                w_data_out_d = '0;
            end
            default: w_state_d = CHR_IDLE;
        endcase
    end

    // State and reply registers; reset wins, otherwise everything advances only on clk_oe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CHR_IDLE;
            r_op_set   <= 1'b0;
            r_chan     <= '0;
            r_wdata    <= '0;
            r_tid      <= '0;
            r_tmo      <= '0;
            r_pulse    <= 1'b0;
            r_msg_out  <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
        end else if (i_clk_oe) begin
            r_state    <= w_state_d;
            r_op_set   <= w_op_set_d;
            r_chan     <= w_chan_d;
            r_wdata    <= w_wdata_d;
            r_tid      <= w_tid_d;
            r_tmo      <= w_tmo_d;
            r_pulse    <= w_pulse_d;
            r_msg_out  <= w_msg_out_d;
            r_addr_out <= w_addr_out_d;
            r_data_out <= w_data_out_d;
        end
    end

    assign bus.cpu_msg_pulse = r_pulse;
    assign bus.cpu_msg_out   = r_msg_out;
    assign bus.addr_out      = r_addr_out;
    assign bus.data_out      = r_data_out;
    assign bus.busy          = (r_state != CHR_IDLE);

endmodule
